uart_boot_loader: RTL
=====================

Name: uart_boot_loader

Overview:
- Receive-side counterpart of the UART status transmitter: accepts a framed program image on uart_rx and writes it as 16-bit words into the program BSRAM.
- Replaces the hard-coded boot image; drives the BSRAM port directly while boot_mode=1, then releases memory to the CPU.
- 8N1 UART receiver, byte framer and memory-write sequencer in one block.

Parameters:
- CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); legal range >=4.
- ADDR_WIDTH, 11, BSRAM word-address width.
- MAX_WORDS, 2048, largest accepted word count; must be <= 2**ADDR_WIDTH.
- SYNC_BYTE, 8'h55, frame start marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- uart_rx  in  1  serial input; idle high; asynchronous to clk.
- mem_ad  out  ADDR_WIDTH  BSRAM word address.
- mem_din  out  16  BSRAM write data.
- mem_wre  out  1  BSRAM write enable; one-cycle pulse per word.
- boot_mode  out  1  1 = loader owns memory and CPU is held; 0 = load complete.
- done  out  1  sticky; image loaded successfully.
- error  out  1  sticky; length, framing or checksum failure.

Behaviour:
- Reset values: mem_ad=0, mem_din=0, mem_wre=0, boot_mode=1, done=0, error=0, synchroniser flops=1, both FSMs at idle, word index=0, checksum=0.
- uart_rx passes through a 2-FF synchroniser before use. All logic sees the synchronised value.
- RX FSM states:
  - R_IDLE: wait for a low level.
  - R_START: at CLKS_PER_BIT/2, if the line is still low go to R_DATA; if high, it is a glitch, return to R_IDLE with no byte.
  - R_DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - R_STOP: sample one bit later. If 1, emit a one-cycle byte strobe. If 0, raise a framing error.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN words each sent low byte then high byte, then CSUM (CSUM only with the optional feature).
- Protocol FSM states:
  - P_SYNC: bytes other than SYNC_BYTE are ignored.
  - P_LEN_LO, P_LEN_HI: LEN is 16 bits. LEN > MAX_WORDS goes to P_ERROR. LEN == 0 goes to P_CSUM, or to P_DONE if the feature is absent.
  - P_DATA_LO: latch the low byte.
  - P_DATA_HI: on the strobe, the next cycle drives mem_wre=1 for exactly 1 cycle with mem_ad=index and mem_din={hi,lo}. The index increments after that write. After word LEN-1, go to P_CSUM or P_DONE.
  - P_CSUM: compare the received byte with the running checksum. Match goes to P_DONE; mismatch goes to P_ERROR.
  - P_DONE: done=1 and boot_mode=0 one cycle after the final byte strobe (or after the final write). Further rx bytes are ignored. Held until rst.
  - P_ERROR: error=1 and boot_mode stays 1. Further bytes are ignored. Held until rst.
- A framing error in any P_ state other than P_SYNC goes to P_ERROR. In P_SYNC a framing error is ignored and the byte is dropped.
- Words already written before an error are not rolled back.
- mem_ad holds its last value between writes. mem_wre is never high for 2 consecutive cycles.
- mem_ad/index width is ADDR_WIDTH. The index never wraps because LEN <= MAX_WORDS.
- rst asserted mid-byte or mid-frame: everything returns to reset values on the next clk edge. The next frame loads from address 0.

Optional Feature:
- Macro UART_BOOT_LOADER_CHECKSUM_EN.
- Defined: the checksum register starts at 8'h00 and XORs every data byte (low and high bytes; not SYNC or LEN). The CSUM byte is required, and a mismatch sets error.
- Undefined: no checksum logic. The FSM goes directly from the last word (or from LEN==0) to P_DONE, and a byte after the last word is ignored.

Test Plan:
- Checksum on, CLKS_PER_BIT=4: send 55 02 00 A1 00 02 90 33 -> writes (ad0, 16'h00A1) then (ad1, 16'h9002), each with a one-cycle wre; done=1, boot_mode=0, error=0.
- Send 00 FF 13 then the frame above -> junk produces no writes; same two writes and done=1.
- Send 55 01 08 (LEN=2049) -> error=1, mem_wre never asserted, boot_mode=1.
- Send 55 01 00 34 12 00 (correct CSUM is 26) -> write (ad0, 16'h1234) occurs; then error=1, done=0.
- In P_SYNC, a 1-clk low glitch gives no byte. After 55, a byte with stop bit 0 gives error=1.
- Assert rst for 1 cycle after the first data word, then send the full frame from the first scenario -> all outputs reset; writes restart at ad0; done=1.

Source files
------------

// File: rtl/uart_boot_loader.sv
// UART 8N1 boot loader: SYNC, LEN_LO, LEN_HI, LEN x {lo,hi} words (+CSUM with UART_BOOT_LOADER_CHECKSUM_EN) -> BSRAM writes.
// Latency: mem_wre one clk after the high-byte stop sample; done/error one clk after the final byte strobe.
// Backpressure: none; the serial link cannot be stalled, so every byte is consumed as it arrives.
module uart_boot_loader #(
  parameter int         CLKS_PER_BIT = 234,
  parameter int         ADDR_WIDTH   = 11,
  parameter int         MAX_WORDS    = 2048,
  parameter logic [7:0] SYNC_BYTE    = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic [ADDR_WIDTH-1:0] mem_ad,
  output logic [15:0]           mem_din,
  output logic                  mem_wre,
  output logic                  boot_mode,
  output logic                  done,
  output logic                  error
);
  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int              HALF    = CLKS_PER_BIT / 2;
  localparam logic [16:0]     MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_LEN_LO, P_LEN_HI, P_DATA_LO, P_DATA_HI,
                            P_CSUM, P_DONE, P_ERROR} p_state_t;

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam p_state_t P_END = P_CSUM;
`else
  localparam p_state_t P_END = P_DONE;
`endif

  logic             rx_meta, rx_s;
  rx_state_t        r_state, r_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             bit_tick, byte_vld, frame_err;

  p_state_t              p_state, p_next;
  logic [7:0]            lo_byte;
  logic [15:0]           len, len_rx;
  logic [ADDR_WIDTH-1:0] index;
  logic                  last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------- RX bit engine ----------------
  assign bit_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next    = r_state;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    case (r_state)
      R_IDLE:  if (!rx_s) r_next = R_START;
      R_START: if (cnt == CNT_W'(HALF - 1)) r_next = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (bit_tick && bit_idx == 3'd7) r_next = R_STOP;
      R_STOP: begin
        if (bit_tick) begin
          r_next    = R_IDLE;
          byte_vld  = rx_s;
          frame_err = !rx_s;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // cnt restarts on every state change and at each bit boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      rx_byte <= 8'h00;
    end else begin
      if (r_state == R_IDLE || r_next != r_state || bit_tick) cnt <= '0;
      else                                                     cnt <= cnt + 1'b1;
      if (r_state == R_DATA && bit_tick) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // ---------------- protocol sequencer ----------------
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk) begin
    if (rst)                                                          csum <= 8'h00;
    else if (byte_vld && (p_state == P_DATA_LO || p_state == P_DATA_HI)) csum <= csum ^ rx_byte;
  end
`endif

  assign len_rx    = {rx_byte, lo_byte};
  assign last_word = (17'(index) == 17'(len) - 17'd1);

  always_ff @(posedge clk) begin
    if (rst) p_state <= P_SYNC;
    else     p_state <= p_next;
  end

  always_comb begin
    p_next = p_state;
    case (p_state)
      P_SYNC:    if (byte_vld && rx_byte == SYNC_BYTE) p_next = P_LEN_LO;
      P_LEN_LO:  if (byte_vld) p_next = P_LEN_HI;
      P_LEN_HI: begin
        if (byte_vld) begin
          if ({1'b0, len_rx} > MAX_LEN) p_next = P_ERROR;
          else if (len_rx == 16'd0)     p_next = P_END;
          else                          p_next = P_DATA_LO;
        end
      end
      P_DATA_LO: if (byte_vld) p_next = P_DATA_HI;
      P_DATA_HI: if (byte_vld) p_next = last_word ? P_END : P_DATA_LO;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      P_CSUM:    if (byte_vld) p_next = (rx_byte == csum) ? P_DONE : P_ERROR;
`endif
      default:   p_next = p_state;
    endcase
    // a bad stop bit inside a frame poisons it; before SYNC it is just noise
    if (frame_err && p_state inside {P_LEN_LO, P_LEN_HI, P_DATA_LO, P_DATA_HI, P_CSUM})
      p_next = P_ERROR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_byte <= 8'h00;
      len     <= 16'd0;
      index   <= '0;
      mem_ad  <= '0;
      mem_din <= 16'h0000;
      mem_wre <= 1'b0;
    end else begin
      mem_wre <= 1'b0;
      if (byte_vld) begin
        case (p_state)
          P_LEN_LO:  lo_byte <= rx_byte;
          P_LEN_HI:  len     <= len_rx;
          P_DATA_LO: lo_byte <= rx_byte;
          P_DATA_HI: begin
            mem_wre <= 1'b1;
            mem_ad  <= index;
            mem_din <= {rx_byte, lo_byte};
            index   <= index + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign done      = (p_state == P_DONE);
  assign error     = (p_state == P_ERROR);
  assign boot_mode = (p_state != P_DONE);
endmodule
